pc_hazard_unit: RTL and testbench
=================================

// Module: pc_hazard_unit
// PURPOSE
//  Parametrised hazard/forwarding unit for the 5-stage pipelined CPU; sits beside the ID-stage decoder.
//  Produces ID-stage forwarding selects, load-use stall and E-stage bubble.
//  Adds tracking of one in-flight multi-cycle mul/div op with RAW/WAW interlock.
//  Adds optional branch flush for no-delay-slot mode and a saturating stall-cycle counter.
// PARAMETERS
//  AW          5    register-address width (2**AW architectural regs, reg 0 hard-wired zero)
//  MD_LAT      8    mul/div latency in cycles from issue to result write, legal range 2..255
//  DELAY_SLOT  1    1: branch delay slot, flush_if never asserted; 0: taken branch/jump flushes IF
//  SCW         16   stall-counter width
// PORTS
//  clock       in   1      rising-edge clock
//  resetn      in   1      asynchronous, active-low reset
//  d_rs        in   AW     ID source reg rs
//  d_rt        in   AW     ID source reg rt
//  d_use_rs    in   1      ID instruction reads rs
//  d_use_rt    in   1      ID instruction reads rt
//  d_wr        in   1      ID instruction writes a reg
//  d_rd        in   AW     ID destination reg
//  d_md        in   1      ID instruction is mul/div
//  d_taken     in   1      ID branch/jump resolved taken (pcsource!=0)
//  e_wreg      in   1      E-stage write enable
//  e_m2reg     in   1      E-stage is a load
//  e_rn        in   AW     E-stage destination reg
//  m_wreg      in   1      M-stage write enable
//  m_m2reg     in   1      M-stage is a load
//  m_rn        in   AW     M-stage destination reg
//  wpcir       out  1      1 = PC and IF/ID advance; 0 = hold
//  bubble      out  1      1 = ID/E latches a NOP (wreg/wmem forced 0)
//  fwda        out  2      rs operand select
//  fwdb        out  2      rt operand select
//  flush_if    out  1      squash fetched instruction in IF/ID
//  md_busy     out  1      mul/div in flight
//  md_done     out  1      one-cycle pulse: result written this cycle
//  md_rd       out  AW     destination of in-flight mul/div
//  stall_cnt   out  SCW    cycles with wpcir=0, saturating at all-ones
// BEHAVIOUR
//  Forwarding, per operand, reg X in {rs,rt}, priority top-down; X==0 always gives 00:
//   - 01 if e_wreg & ~e_m2reg & e_rn==X
//   - 10 if m_wreg & ~m_m2reg & m_rn==X
//   - 11 if m_wreg & m_m2reg & m_rn==X
//   - otherwise 00
//  Stall conditions; stall = OR of all, combinational; wpcir = ~stall, bubble = stall:
//   - load_use: e_wreg & e_m2reg & e_rn!=0 & ((d_use_rs & e_rn==d_rs) | (d_use_rt & e_rn==d_rt))
//   - md_raw: md_busy & md_rd!=0 & (d_use_rs & d_rs==md_rd | d_use_rt & d_rt==md_rd | d_wr & d_rd==md_rd)
//   - md_struct: md_busy & d_md
//  MD tracker FSM, IDLE -> BUSY -> IDLE:
//   - issue when d_md & ~stall in IDLE: cnt<=MD_LAT-1, md_rd<=d_rd, md_busy<=1
//   - BUSY: cnt decrements each cycle; at cnt==1, next cycle md_done=1, md_busy=0
//   - md_done is registered, exactly 1 cycle; busy spans MD_LAT-1 cycles
//   - a new issue is allowed in the same cycle md_done is high
//   - md_rd holds its value after done; it is 0 after reset
//  flush_if: DELAY_SLOT=0 gives d_taken & wpcir; DELAY_SLOT=1 gives 0. A stalled branch does not flush.
//  stall_cnt: +1 on each clock edge where stall=1; holds at 2**SCW-1.
//  Reset (any time, including mid mul/div):
//   - md_busy=0, md_done=0, md_rd=0, cnt=0, stall_cnt=0
//   - combinational outputs follow inputs; in-flight op is abandoned
//  Sequential state is exactly: cnt ($clog2(MD_LAT) bits), md_busy, md_done, md_rd, stall_cnt.
// STRUCTURE
//  - pc_pkg: localparams FWD_REG=2'b00, FWD_EALU=2'b01, FWD_MALU=2'b10, FWD_MMEM=2'b11.
//  - Sub-module pc_md_tracker: counter, busy/done, md_rd latch; parameters AW, MD_LAT.
//  - Forwarding, stall and flush logic stay in the top module.
// TESTING
//  1. e_wreg=1,e_m2reg=0,e_rn=5; m_wreg=1,m_rn=5; d_rs=5 -> fwda=01; with e_wreg=0 -> fwda=10.
//  2. e_wreg=1,e_m2reg=1,e_rn=7; d_use_rt=1,d_rt=7 -> wpcir=0,bubble=1 one cycle; stall_cnt 0->1; e_rn=0 -> no stall.
//  3. MD_LAT=4; issue d_md=1,d_rd=9 at cycle 0 -> md_busy cycles 1-3, md_done cycle 4, md_rd=9.
//  4. Same issue; then d_use_rs=1,d_rs=9 -> stalled until md_done; d_md=1 second op stalled until done, issued in done cycle.
//  5. DELAY_SLOT=0, d_taken=1 -> flush_if=1; add load_use stall -> flush_if=0.
//  6. resetn low at cycle 2 of MD_LAT=8 op -> md_busy=0,md_done=0,stall_cnt=0 immediately; no md_done pulse afterwards.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared encodings for the pipeline hazard/forwarding unit: operand-select
// codes and the mul/div tracker state type.
package pc_pkg;

  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_EALU = 2'b01;
  localparam logic [1:0] FWD_MALU = 2'b10;
  localparam logic [1:0] FWD_MMEM = 2'b11;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/pc_md_tracker.sv
// Tracks one in-flight multi-cycle mul/div: down-counter from issue to result
// write, busy flag, one-cycle done pulse and the latched destination register.
module pc_md_tracker
  import pc_pkg::*;
#(
  parameter int AW     = 5,
  parameter int MD_LAT = 8
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          issue,
  input  logic [AW-1:0] issue_rd,
  output logic          md_busy,
  output logic          md_done,
  output logic [AW-1:0] md_rd
);

  localparam int CW = $clog2(MD_LAT);

  md_state_e     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          done_nxt;
  logic [AW-1:0] rd_nxt;

  // The state register is the busy flag itself.
  assign md_busy = (state == MD_BUSY);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      md_done <= 1'b0;
      md_rd   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      md_done <= done_nxt;
      md_rd   <= rd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    rd_nxt    = md_rd;
    case (state)
      MD_IDLE: begin
        if (issue) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = CW'(MD_LAT - 1);
          rd_nxt    = issue_rd;
        end
      end
      MD_BUSY: begin
        cnt_nxt = cnt - CW'(1);
        // Last busy cycle: result lands on the next edge.
        if (cnt == CW'(1)) begin
          state_nxt = MD_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = MD_IDLE;
    endcase
  end

endmodule

// File: rtl/pc_hazard_unit.sv
// ID-stage hazard unit: operand forwarding selects, load-use and mul/div
// interlocks, optional taken-branch IF flush and a saturating stall counter.
module pc_hazard_unit
  import pc_pkg::*;
#(
  parameter int AW         = 5,
  parameter int MD_LAT     = 8,
  parameter int DELAY_SLOT = 1,
  parameter int SCW        = 16
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic [AW-1:0]  d_rs,
  input  logic [AW-1:0]  d_rt,
  input  logic           d_use_rs,
  input  logic           d_use_rt,
  input  logic           d_wr,
  input  logic [AW-1:0]  d_rd,
  input  logic           d_md,
  input  logic           d_taken,
  input  logic           e_wreg,
  input  logic           e_m2reg,
  input  logic [AW-1:0]  e_rn,
  input  logic           m_wreg,
  input  logic           m_m2reg,
  input  logic [AW-1:0]  m_rn,
  output logic           wpcir,
  output logic           bubble,
  output logic [1:0]     fwda,
  output logic [1:0]     fwdb,
  output logic           flush_if,
  output logic           md_busy,
  output logic           md_done,
  output logic [AW-1:0]  md_rd,
  output logic [SCW-1:0] stall_cnt
);

  logic load_use, md_raw, md_struct, stall;

  // Nearest producer wins; register 0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] x);
    logic [1:0] sel;
    sel = FWD_REG;
    if (x != '0) begin
      if (e_wreg && !e_m2reg && e_rn == x)      sel = FWD_EALU;
      else if (m_wreg && !m_m2reg && m_rn == x) sel = FWD_MALU;
      else if (m_wreg && m_m2reg && m_rn == x)  sel = FWD_MMEM;
    end
    return sel;
  endfunction

  assign fwda = fwd_sel(d_rs);
  assign fwdb = fwd_sel(d_rt);

  assign load_use  = e_wreg && e_m2reg && (e_rn != '0) &&
                     ((d_use_rs && e_rn == d_rs) || (d_use_rt && e_rn == d_rt));
  assign md_raw    = md_busy && (md_rd != '0) &&
                     ((d_use_rs && d_rs == md_rd) || (d_use_rt && d_rt == md_rd) ||
                      (d_wr && d_rd == md_rd));
  assign md_struct = md_busy && d_md;
  assign stall     = load_use || md_raw || md_struct;

  assign wpcir    = !stall;
  assign bubble   = stall;
  // A stalled branch is re-presented next cycle, so it must not flush yet.
  assign flush_if = (DELAY_SLOT == 0) && d_taken && wpcir;

  pc_md_tracker #(
    .AW     (AW),
    .MD_LAT (MD_LAT)
  ) u_md (
    .clock    (clock),
    .resetn   (resetn),
    .issue    (d_md && !stall),
    .issue_rd (d_rd),
    .md_busy  (md_busy),
    .md_done  (md_done),
    .md_rd    (md_rd)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + SCW'(1);
  end

endmodule

// File: tb/tb_pc_hazard_unit.sv
// Directed bench for pc_hazard_unit with a cycle-level reference model that
// is compared against the DUT on every falling clock edge.
module tb_pc_hazard_unit;

  localparam int AW     = 5;
  localparam int MD_LAT = 4;
  localparam int DS     = 0;
  localparam int SCW    = 4;
  localparam int SMAX   = (1 << SCW) - 1;

  logic          clock = 1'b0;
  logic          resetn;
  logic [AW-1:0] d_rs, d_rt, d_rd, e_rn, m_rn;
  logic          d_use_rs, d_use_rt, d_wr, d_md, d_taken;
  logic          e_wreg, e_m2reg, m_wreg, m_m2reg;
  logic          wpcir, bubble, flush_if, md_busy, md_done;
  logic [1:0]    fwda, fwdb;
  logic [AW-1:0] md_rd;
  logic [SCW-1:0] stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: issue bookkeeping in absolute cycle numbers.
  bit            pending  = 1'b0;
  int            done_cyc = 0;
  int            cyc      = 0;
  int            scnt     = 0;
  logic [AW-1:0] m_rd     = '0;

  always #5 clock = ~clock;

  pc_hazard_unit #(
    .AW(AW), .MD_LAT(MD_LAT), .DELAY_SLOT(DS), .SCW(SCW)
  ) dut (
    .clock(clock), .resetn(resetn),
    .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
    .d_wr(d_wr), .d_rd(d_rd), .d_md(d_md), .d_taken(d_taken),
    .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_rn(e_rn),
    .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_rn(m_rn),
    .wpcir(wpcir), .bubble(bubble), .fwda(fwda), .fwdb(fwdb),
    .flush_if(flush_if), .md_busy(md_busy), .md_done(md_done),
    .md_rd(md_rd), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  function automatic int m_fwd(input logic [AW-1:0] x);
    if (x == 0) return 0;
    if (e_wreg && !e_m2reg && e_rn == x) return 1;
    if (m_wreg && !m_m2reg && m_rn == x) return 2;
    if (m_wreg && m_m2reg && m_rn == x) return 3;
    return 0;
  endfunction

  function automatic bit m_busy();
    return pending && (cyc < done_cyc);
  endfunction

  function automatic bit m_done();
    return pending && (cyc == done_cyc);
  endfunction

  function automatic bit m_stall();
    bit lu, raw;
    lu  = e_wreg && e_m2reg && e_rn != 0 &&
          ((d_use_rs && e_rn == d_rs) || (d_use_rt && e_rn == d_rt));
    raw = m_busy() && m_rd != 0 &&
          ((d_use_rs && d_rs == m_rd) || (d_use_rt && d_rt == m_rd) || (d_wr && d_rd == m_rd));
    return lu || raw || (m_busy() && d_md);
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pending = 1'b0;
      m_rd    = '0;
      scnt    = 0;
    end else begin
      bit s;
      s = m_stall();
      if (!s && d_md) begin
        pending  = 1'b1;
        done_cyc = cyc + MD_LAT;
        m_rd     = d_rd;
      end
      if (s && scnt < SMAX) scnt++;
      cyc++;
    end
  end

  always @(negedge clock) begin
    chk("m_fwda",      fwda,      m_fwd(d_rs));
    chk("m_fwdb",      fwdb,      m_fwd(d_rt));
    chk("m_wpcir",     wpcir,     !m_stall());
    chk("m_bubble",    bubble,    m_stall());
    chk("m_flush_if",  flush_if,  (DS == 0) && d_taken && !m_stall());
    chk("m_md_busy",   md_busy,   m_busy());
    chk("m_md_done",   md_done,   m_done());
    chk("m_md_rd",     md_rd,     m_rd);
    chk("m_stall_cnt", stall_cnt, scnt);
  end

  task automatic clear_in();
    d_rs = '0; d_rt = '0; d_rd = '0; e_rn = '0; m_rn = '0;
    d_use_rs = 0; d_use_rt = 0; d_wr = 0; d_md = 0; d_taken = 0;
    e_wreg = 0; e_m2reg = 0; m_wreg = 0; m_m2reg = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetn = 1'b1;
    clear_in();
    #1 resetn = 1'b0;
    @(negedge clock);
    chk("rst_md_busy", md_busy, 0);
    chk("rst_md_done", md_done, 0);
    chk("rst_md_rd", md_rd, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    @(negedge clock);
    #1 resetn = 1'b1;

    // Forwarding priority
    tick();
    e_wreg = 1; e_rn = 5; m_wreg = 1; m_rn = 5; d_rs = 5; d_rt = 5; d_use_rs = 1;
    @(negedge clock);
    chk("t1_fwda_ealu", fwda, 2'b01);
    chk("t1_fwdb_ealu", fwdb, 2'b01);
    tick();
    e_wreg = 0;
    @(negedge clock);
    chk("t1_fwda_malu", fwda, 2'b10);
    tick();
    m_m2reg = 1;
    @(negedge clock);
    chk("t1_fwda_mmem", fwda, 2'b11);
    chk("t1_no_stall", wpcir, 1);
    tick();
    d_rs = 0; e_wreg = 1; e_rn = 0;
    @(negedge clock);
    chk("t1_fwda_r0", fwda, 2'b00);
    chk("t1_fwdb_mmem", fwdb, 2'b11);

    // Load-use
    tick();
    clear_in();
    e_wreg = 1; e_m2reg = 1; e_rn = 7; d_use_rt = 1; d_rt = 7;
    @(negedge clock);
    chk("t2_wpcir", wpcir, 0);
    chk("t2_bubble", bubble, 1);
    chk("t2_cnt0", stall_cnt, 0);
    tick();
    clear_in();
    @(negedge clock);
    chk("t2_wpcir_after", wpcir, 1);
    chk("t2_cnt1", stall_cnt, 1);
    tick();
    e_wreg = 1; e_m2reg = 1; e_rn = 0; d_use_rt = 1; d_rt = 0;
    @(negedge clock);
    chk("t2_r0_no_stall", wpcir, 1);

    // Mul/div issue, RAW, structural and WAW interlocks
    tick();
    clear_in();
    d_md = 1; d_wr = 1; d_rd = 9;
    @(negedge clock);
    chk("t3_issue_wpcir", wpcir, 1);
    chk("t3_idle", md_busy, 0);
    tick();
    clear_in();
    d_use_rs = 1; d_rs = 9;
    @(negedge clock);
    chk("t3_busy1", md_busy, 1);
    chk("t3_md_rd", md_rd, 9);
    chk("t4_raw_stall", wpcir, 0);
    tick();
    clear_in();
    d_md = 1; d_wr = 1; d_rd = 3;
    @(negedge clock);
    chk("t4_struct_stall", wpcir, 0);
    tick();
    @(negedge clock);
    chk("t3_busy3", md_busy, 1);
    tick();
    @(negedge clock);
    chk("t3_done", md_done, 1);
    chk("t3_busy_drop", md_busy, 0);
    chk("t4_issue_on_done", wpcir, 1);
    chk("t3_rd_hold", md_rd, 9);
    tick();
    clear_in();
    d_wr = 1; d_rd = 3;
    @(negedge clock);
    chk("t4_second_busy", md_busy, 1);
    chk("t4_second_rd", md_rd, 3);
    chk("t4_done_pulse", md_done, 0);
    chk("t4_waw_stall", wpcir, 0);
    chk("t4_cnt", stall_cnt, 4);
    tick(); clear_in();
    tick();
    tick();
    @(negedge clock);
    chk("t4_second_done", md_done, 1);

    // Branch flush, suppressed under stall
    tick();
    clear_in();
    d_taken = 1;
    @(negedge clock);
    chk("t5_flush", flush_if, 1);
    tick();
    e_wreg = 1; e_m2reg = 1; e_rn = 4; d_use_rs = 1; d_rs = 4;
    @(negedge clock);
    chk("t5_no_flush", flush_if, 0);
    chk("t5_stall", wpcir, 0);
    repeat (20) tick();
    @(negedge clock);
    chk("sat_cnt", stall_cnt, SMAX);

    // Reset in the middle of a mul/div
    tick();
    clear_in();
    d_md = 1; d_wr = 1; d_rd = 12;
    @(negedge clock);
    chk("t6_issue", wpcir, 1);
    tick();
    clear_in();
    d_use_rs = 1; d_rs = 12;
    @(negedge clock);
    chk("t6_busy", md_busy, 1);
    tick();
    resetn = 1'b0;
    #1;
    chk("t6_rst_busy", md_busy, 0);
    chk("t6_rst_done", md_done, 0);
    chk("t6_rst_cnt", stall_cnt, 0);
    chk("t6_rst_rd", md_rd, 0);
    chk("t6_rst_wpcir", wpcir, 1);
    @(negedge clock);
    #1 resetn = 1'b1;
    tick();
    tick();
    @(negedge clock);
    chk("t6_no_done", md_done, 0);
    chk("t6_no_busy", md_busy, 0);
    chk("t6_cnt_zero", stall_cnt, 0);
    tick(); clear_in();
    tick();
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
